counter_sequencer: RTL and testbench

Command-driven controller for a WIDTH-bit synchronous up/down counter. It accepts one counting job at a time over a valid/ready handshake: start value, direction and step count. It then steps the embedded counter once per cycle, honouring a hold input, and reports completion and wrap-around. It is the sequencing layer placed in front of the up/down counter datapath, so that other logic can issue bounded count jobs instead of free-running the counter.

---
 rtl/counter_sequencer_if.sv | 46 ++++
 rtl/counter_sequencer.sv | 107 ++++++++++
 tb/tb_counter_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer_if
// Description : Command / status bundle for counter_sequencer.
//               master = job issuer, slave = counter_sequencer.
//               Signals: cmd_valid, cmd_ready, cmd_dir, cmd_start, cmd_steps,
//               hold, count, busy, done, wrap, and abort when the macro
//               COUNTER_SEQ_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_steps;
  logic             hold;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;
`ifdef COUNTER_SEQ_ABORT_EN
  logic             abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_start, cmd_steps, hold, abort,
    input  cmd_ready, count, busy, done, wrap
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_start, cmd_steps, hold, abort,
    output cmd_ready, count, busy, done, wrap
  );
`else
  modport master (
    output cmd_valid, cmd_dir, cmd_start, cmd_steps, hold,
    input  cmd_ready, count, busy, done, wrap
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_start, cmd_steps, hold,
    output cmd_ready, count, busy, done, wrap
  );
`endif
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Accepts one bounded count job (start value, direction, step
//               count) over a valid/ready handshake and steps an embedded
//               WIDTH-bit up/down counter once per cycle, honouring hold.
//               Reports a one-cycle done pulse and per-step wrap pulses.
// Ports       : clk_i   - rising-edge clock
//               reset_i - synchronous active-high reset
//               bus     - counter_sequencer_if.slave (command + status)
// Options     : COUNTER_SEQ_ABORT_EN - adds bus.abort, which ends a running
//               job early (no step that cycle, done still pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  wire logic          clk_i,
  input  wire logic          reset_i,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             abort_w;

`ifdef COUNTER_SEQ_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      wrap_q      <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    wrap_d      = 1'b0;   // wrap is a pulse: only a wrapping step raises it
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          dir_d       = bus.cmd_dir;
          count_d     = bus.cmd_start;
          remaining_d = bus.cmd_steps;
          state_d     = (bus.cmd_steps != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort_w) begin
          // Early termination: counter keeps its value, done still pulses.
          state_d = ST_DONE;
        end else if (!bus.hold) begin
          if (dir_q) begin
            count_d = count_q + 1'b1;
            wrap_d  = (count_q == {WIDTH{1'b1}});
          end else begin
            count_d = count_q - 1'b1;
            wrap_d  = (count_q == '0);
          end
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.count     = count_q;
  assign bus.wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Self-checking bench for counter_sequencer. Job vectors from a
//               table plus hand sequences for reset, mid-job reset and abort.
//               Expected per-cycle status is queued as stimulus is driven and
//               compared one cycle later against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

  localparam int W = 4;

  logic clk_i;
  logic reset_i;

  counter_sequencer_if #(.WIDTH(W)) bus ();

  counter_sequencer #(.WIDTH(W)) u_dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [W-1:0] count;
    logic         ready;
    logic         busy;
    logic         done;
    logic         wrap;
  } rec_t;

  typedef struct {
    logic         dir;
    logic [W-1:0] start;
    logic [W-1:0] steps;
    int           hold_at;
    int           hold_len;
    bit           valid_stay;
    logic [W-1:0] final_cnt;
  } vec_t;

  rec_t sb[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_rec(input logic [W-1:0] c, input logic r, input logic b,
                          input logic d, input logic w);
    rec_t e;
    e.count = c; e.ready = r; e.busy = b; e.done = d; e.wrap = w;
    sb.push_back(e);
  endtask

  // Advance one clock and compare the DUT status to the oldest expectation.
  task automatic chk(input string name);
    rec_t e;
    rec_t a;
    @(posedge clk_i);
    #1;
    a = {bus.count, bus.cmd_ready, bus.busy, bus.done, bus.wrap};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: no expectation queued (scoreboard empty)", name);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got count=%0d rdy=%b busy=%b done=%b wrap=%b, expected count=%0d rdy=%b busy=%b done=%b wrap=%b",
                 name, a.count, a.ready, a.busy, a.done, a.wrap,
                 e.count, e.ready, e.busy, e.done, e.wrap);
      end
    end
  endtask

  // Issue a job from IDLE and check every cycle through the IDLE cycle after done.
  task automatic run_job(input vec_t v, input string name);
    logic [W-1:0] c;
    int           rem;
    int           e;
    bit           h;
    bit           wv;
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = v.dir;
    bus.cmd_start = v.start;
    bus.cmd_steps = v.steps;
    bus.hold      = 1'b0;
    c   = v.start;
    rem = int'(v.steps);
    push_rec(c, 1'b0, 1'b1, (rem == 0), 1'b0);
    chk({name, "_accept"});
    if (v.valid_stay) begin
      // A spurious reload would show up as count=F.
      bus.cmd_start = 4'hF;
      bus.cmd_steps = 4'h1;
      bus.cmd_dir   = ~v.dir;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    e = 0;
    while (rem != 0) begin
      e++;
      h = (v.hold_len > 0) && (e >= v.hold_at) && (e < v.hold_at + v.hold_len);
      bus.hold = h;
      wv = 1'b0;
      if (!h) begin
        wv = v.dir ? (c == 4'hF) : (c == 4'h0);
        c  = v.dir ? c + 4'd1 : c - 4'd1;
        rem--;
      end
      push_rec(c, 1'b0, 1'b1, (rem == 0), wv);
      chk({name, "_run"});
    end
    bus.hold = 1'($urandom_range(0, 1));   // hold has no effect in DONE
    push_rec(c, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({name, "_idle"});
    bus.hold = 1'b0;
    checks++;
    if (bus.count !== v.final_cnt) begin
      failures++;
      $display("FAIL %s_final: got count=%0d, expected %0d", name, bus.count, v.final_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //        dir   start  steps hold_at len stay final
    vecs[0] = '{1'b1, 4'd3,  4'd5,  0, 0, 1'b0, 4'd8};   // plain up
    vecs[1] = '{1'b0, 4'd1,  4'd3,  0, 0, 1'b0, 4'd14};  // down through 0
    vecs[2] = '{1'b1, 4'd10, 4'd4,  2, 2, 1'b0, 4'd14};  // hold 2 cycles after step 1
    vecs[3] = '{1'b1, 4'd9,  4'd0,  0, 0, 1'b0, 4'd9};   // zero-length job
    vecs[4] = '{1'b1, 4'd14, 4'd3,  0, 0, 1'b0, 4'd1};   // up through max
    vecs[5] = '{1'b0, 4'd5,  4'd15, 3, 1, 1'b0, 4'd6};   // longest job, one hold
    vecs[6] = '{1'b1, 4'd2,  4'd3,  0, 0, 1'b1, 4'd5};   // cmd_valid kept high
    vecs[7] = '{1'b0, 4'd7,  4'd2,  0, 0, 1'b0, 4'd5};   // back-to-back accept

    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_start = '0;
    bus.cmd_steps = '0;
    bus.hold      = 1'b0;
`ifdef COUNTER_SEQ_ABORT_EN
    bus.abort     = 1'b0;
`endif
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_dir   = 1'($urandom_range(0, 1));
      bus.cmd_start = W'($urandom_range(1, 15));
      bus.cmd_steps = W'($urandom_range(0, 15));
      bus.hold      = 1'($urandom_range(0, 1));
      push_rec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset");
    end
    reset_i       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.hold      = 1'b1;   // ignored in IDLE
    for (int i = 0; i < 2; i++) begin
      push_rec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_reset_idle");
    end
    bus.hold = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a job, with cmd_valid asserted.
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_start = 4'd2; bus.cmd_steps = 4'd8;
    push_rec(4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midreset_accept");
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_rec(W'(2 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("midreset_run");
    end
    reset_i = 1'b1; bus.cmd_valid = 1'b1;
    push_rec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midreset_reset");
    reset_i = 1'b0; bus.cmd_valid = 1'b0;
    push_rec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midreset_nodone");

`ifdef COUNTER_SEQ_ABORT_EN
    // Abort at count=4 of a 10-step up job.
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_start = 4'd0; bus.cmd_steps = 4'd10;
    push_rec(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_accept");
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_rec(W'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("abort_run");
    end
    bus.abort = 1'b1;
    push_rec(4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_done");
    bus.abort = 1'b0;
    push_rec(4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_idle");

    // Abort together with hold: abort wins.
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b0; bus.cmd_start = 4'd3; bus.cmd_steps = 4'd6;
    push_rec(4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("abhold_accept");
    bus.cmd_valid = 1'b0;
    push_rec(4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("abhold_run");
    bus.abort = 1'b1; bus.hold = 1'b1;
    push_rec(4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("abhold_done");
    bus.abort = 1'b0; bus.hold = 1'b0;
    push_rec(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("abhold_idle");
`endif

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
